// File: rtl/fll_cfg_slave.sv
// FLL-side slave of the 4-phase req/ack configuration link: synchronises req, runs register accesses, filters lock.
// Optional lock filter built when FLL_CFG_LOCK_FILTER_EN is defined.
module fll_cfg_slave #(
   parameter logic [31:0] CFG1_RST      = 32'h0000_05F5,
   parameter logic [31:0] CFG2_RST      = 32'h0000_0000,
   parameter logic [31:0] INTEG_RST     = 32'h0000_0000,
   parameter int          LOCK_FILT_CYC = 16
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        fll_req_i,
   input  logic        fll_wrn_i,
   input  logic [1:0]  fll_add_i,
   input  logic [31:0] fll_data_i,
   output logic        fll_ack_o,
   output logic [31:0] fll_r_data_o,
   output logic        fll_lock_o,
   input  logic        lock_raw_i,
   input  logic [15:0] act_mult_i,
   output logic [31:0] cfg1_o,
   output logic [31:0] cfg2_o,
   output logic [31:0] integ_o,
   output logic        cfg_upd_o
);

   typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

   state_t      state_q;
   logic        req_meta_q;
   logic        req_s_q;
   logic        ack_q;
   logic [31:0] r_data_q;
   logic        upd_q;
   logic        lock_q;
   logic [31:0] cfg1_q;
   logic [31:0] cfg2_q;
   logic [31:0] integ_q;
   logic [31:0] rd_mux_d;

   // Only req crosses domains; add/wrn/data are stable by the time req_s is seen high.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         req_meta_q <= 1'b0;
         req_s_q    <= 1'b0;
      end else begin
         req_meta_q <= fll_req_i;
         req_s_q    <= req_meta_q;
      end
   end

   always_comb begin
      rd_mux_d = 32'h0;
      case (fll_add_i)
         2'd0: rd_mux_d = {lock_q, 15'b0, act_mult_i};
         2'd1: rd_mux_d = cfg1_q;
         2'd2: rd_mux_d = cfg2_q;
         2'd3: rd_mux_d = integ_q;
         default: rd_mux_d = 32'h0;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= IDLE;
         ack_q    <= 1'b0;
         r_data_q <= 32'h0;
         upd_q    <= 1'b0;
         cfg1_q   <= CFG1_RST;
         cfg2_q   <= CFG2_RST;
         integ_q  <= INTEG_RST;
      end else begin
         upd_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_s_q) begin
                  state_q <= ACK;
                  ack_q   <= 1'b1;
                  if (fll_wrn_i) begin
                     r_data_q <= rd_mux_d;
                  end else begin
                     case (fll_add_i)
                        2'd1: begin cfg1_q  <= fll_data_i; upd_q <= 1'b1; end
                        2'd2: begin cfg2_q  <= fll_data_i; upd_q <= 1'b1; end
                        2'd3: begin integ_q <= fll_data_i; upd_q <= 1'b1; end
                        default: ;
                     endcase
                  end
               end
            end
            ACK: begin
               // Stay here until req is seen low so one request yields exactly one access.
               if (!req_s_q) begin
                  state_q <= IDLE;
                  ack_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               ack_q   <= 1'b0;
            end
         endcase
      end
   end

`ifdef FLL_CFG_LOCK_FILTER_EN
   localparam int CNT_W = $clog2(LOCK_FILT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILT_CYC);

   logic [CNT_W-1:0] lock_cnt_q;
   logic [CNT_W-1:0] lock_cnt_d;

   always_comb begin
      lock_cnt_d = '0;
      if (lock_raw_i)
         lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= (lock_cnt_d == CNT_MAX);
      end
   end
`else
   // The filter length only matters when the filter is built.
   if (LOCK_FILT_CYC < 1) begin : g_filt_len_unused
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) lock_q <= 1'b0;
      else          lock_q <= lock_raw_i;
   end
`endif

   assign fll_ack_o    = ack_q;
   assign fll_r_data_o = r_data_q;
   assign fll_lock_o   = lock_q;
   assign cfg1_o       = cfg1_q;
   assign cfg2_o       = cfg2_q;
   assign integ_o      = integ_q;
   assign cfg_upd_o    = upd_q;

endmodule
